// File: rtl/wb_fmc516_stream_packer.sv
// Packs four-channel ADC samples into fixed-size pipelined Wishbone stream packets, each followed by a status word.
// One-cycle push-to-level and start latency; stall freezes stb/adr/dat; a push into a full FIFO (with no pop) is dropped.
module wb_fmc516_fifo #(
   parameter int g_width = 64,
   parameter int g_depth = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [g_width-1:0]         wdat,
   output logic [g_width-1:0]         rdat,
   output logic [$clog2(g_depth):0]   level,
   output logic                       drop
);
   localparam int AW = $clog2(g_depth);
   localparam logic [AW:0] FULL_LVL = g_depth[AW:0];

   logic [g_width-1:0] mem [g_depth];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               full;
   logic               empty;
   logic               do_push;
   logic               do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign rdat    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdat;
   end
endmodule

module wb_fmc516_stream_packer #(
   parameter int g_adc_data_width = 16,
   parameter int g_packet_size    = 32,
   parameter int g_fifo_depth     = 256
) (
   input  logic                            sys_clk_i,
   input  logic                            sys_rst_i,
   input  logic                            enable_i,
   input  logic [g_adc_data_width-1:0]     adc_data_ch0_i,
   input  logic [g_adc_data_width-1:0]     adc_data_ch1_i,
   input  logic [g_adc_data_width-1:0]     adc_data_ch2_i,
   input  logic [g_adc_data_width-1:0]     adc_data_ch3_i,
   input  logic                            adc_data_valid_i,
   output logic [1:0]                      wbs_adr_o,
   output logic [4*g_adc_data_width-1:0]   wbs_dat_o,
   output logic                            wbs_cyc_o,
   output logic                            wbs_stb_o,
   output logic                            wbs_we_o,
   output logic [7:0]                      wbs_sel_o,
   input  logic                            wbs_ack_i,
   input  logic                            wbs_stall_i,
   input  logic                            wbs_err_i,
   input  logic                            wbs_rty_i,
   output logic [$clog2(g_fifo_depth):0]   fifo_level_o,
   output logic                            ovf_o,
   output logic                            err_o
);
   localparam int DW  = 4*g_adc_data_width;
   localparam int LW  = $clog2(g_fifo_depth)+1;
   localparam int WCW = $clog2(g_packet_size);
   localparam int OW  = $clog2(g_packet_size+2);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(g_packet_size-1);
   localparam logic [LW-1:0]  START_LVL = LW'(g_packet_size);
   localparam logic [15:0]    PKT_LEN   = 16'(g_packet_size);

   typedef enum logic [1:0] {IDLE, DATA, STATUS, DRAIN} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [WCW-1:0] word_cnt;
   logic [OW-1:0]  outstanding;
   logic [15:0]    ovf_cnt;
   logic [15:0]    pkt_seq;
   logic [DW-1:0]  fifo_head;
   logic [DW-1:0]  status_word;
   logic           drop;
   logic           accept;
   logic           pop;
   logic           resp;
   logic           unused_ok;

   assign unused_ok = wbs_rty_i;

   wb_fmc516_fifo #(
      .g_width (DW),
      .g_depth (g_fifo_depth)
   ) u_fifo (
      .clk   (sys_clk_i),
      .rst   (sys_rst_i),
      .push  (adc_data_valid_i),
      .pop   (pop),
      .wdat  ({adc_data_ch3_i, adc_data_ch2_i, adc_data_ch1_i, adc_data_ch0_i}),
      .rdat  (fifo_head),
      .level (fifo_level_o),
      .drop  (drop)
   );

   assign accept      = wbs_stb_o && !wbs_stall_i;
   assign pop         = (state == DATA) && accept;
   assign resp        = wbs_cyc_o && (wbs_ack_i || wbs_err_i);
   assign status_word = DW'({pkt_seq, ovf_cnt, 16'h0000, PKT_LEN});
   assign wbs_we_o    = wbs_stb_o;
   assign wbs_sel_o   = {8{wbs_stb_o}};
   assign wbs_dat_o   = (state == STATUS) ? status_word : fifo_head;

   always_comb begin
      state_nxt = state;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbs_adr_o = 2'd0;
      case (state)
         IDLE: begin
            // Waiting for a whole packet keeps stb gap-free through DATA.
            if (enable_i && (fifo_level_o >= START_LVL)) state_nxt = DATA;
         end
         DATA: begin
            wbs_cyc_o = 1'b1;
            wbs_stb_o = 1'b1;
            if (!wbs_stall_i && (word_cnt == LAST_WORD)) state_nxt = STATUS;
         end
         STATUS: begin
            wbs_cyc_o = 1'b1;
            wbs_stb_o = 1'b1;
            wbs_adr_o = 2'd1;
            if (!wbs_stall_i) state_nxt = DRAIN;
         end
         DRAIN: begin
            wbs_cyc_o = 1'b1;
            if (outstanding == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state       <= IDLE;
         word_cnt    <= '0;
         outstanding <= '0;
         ovf_cnt     <= '0;
         pkt_seq     <= '0;
         ovf_o       <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state <= state_nxt;
         ovf_o <= drop;
         if (pop) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
         if (accept && !resp) begin
            outstanding <= outstanding + 1'b1;
         end else if (!accept && resp && (outstanding != '0)) begin
            outstanding <= outstanding - 1'b1;
         end
         // A drop coinciding with the status handshake belongs to the next packet.
         if ((state == STATUS) && accept) begin
            ovf_cnt <= drop ? 16'd1 : 16'd0;
         end else if (drop && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
         end
         if ((state == DRAIN) && (outstanding == '0)) pkt_seq <= pkt_seq + 16'd1;
         if (resp && wbs_err_i) err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_wb_fmc516_stream_packer.sv
// Directed bench for wb_fmc516_stream_packer: a Wishbone responder process plus one task per scenario.
module tb_wb_fmc516_stream_packer;
   logic        clk = 1'b0;
   logic        rst, en, vld;
   logic [15:0] ch0, ch1, ch2, ch3;
   logic [1:0]  adr;
   logic [63:0] dat;
   logic        cyc, stb, we;
   logic [7:0]  sel;
   logic        ack, stall, err, rty;
   logic [8:0]  level;
   logic        ovf, err_flag;

   always #5 clk = ~clk;

   wb_fmc516_stream_packer #(
      .g_adc_data_width (16),
      .g_packet_size    (32),
      .g_fifo_depth     (256)
   ) dut (
      .sys_clk_i        (clk),
      .sys_rst_i        (rst),
      .enable_i         (en),
      .adc_data_ch0_i   (ch0),
      .adc_data_ch1_i   (ch1),
      .adc_data_ch2_i   (ch2),
      .adc_data_ch3_i   (ch3),
      .adc_data_valid_i (vld),
      .wbs_adr_o        (adr),
      .wbs_dat_o        (dat),
      .wbs_cyc_o        (cyc),
      .wbs_stb_o        (stb),
      .wbs_we_o         (we),
      .wbs_sel_o        (sel),
      .wbs_ack_i        (ack),
      .wbs_stall_i      (stall),
      .wbs_err_i        (err),
      .wbs_rty_i        (rty),
      .fifo_level_o     (level),
      .ovf_o            (ovf),
      .err_o            (err_flag)
   );

   int total = 0;
   int bad   = 0;

   // Responder configuration (written by tests only)
   int stall_mode = 0;
   int ack_delay  = 1;
   int err_at     = -1;

   // Responder observations (written by the responder only)
   int          ncyc = 0, resp_cnt = 0, acc_cnt = 0, stb_cycles = 0;
   int          hold_viol = 0, ovf_seen = 0, cyc_rises = 0;
   logic        last_resp_cyc = 1'b0;
   logic [63:0] cap_dat[$];
   logic [1:0]  cap_adr[$];
   int          due[$];
   logic        prev_held = 1'b0, prev_cyc = 1'b0;
   logic [63:0] prev_dat;
   logic [1:0]  prev_adr;

   initial begin
      ack = 1'b0; err = 1'b0; stall = 1'b0; rty = 1'b0;
      forever begin
         @(negedge clk);
         ncyc++;
         ack = 1'b0;
         err = 1'b0;
         if (ovf === 1'b1) ovf_seen++;
         if (cyc === 1'b1 && prev_cyc !== 1'b1) cyc_rises++;
         prev_cyc = cyc;
         if (rst === 1'b1) begin
            due.delete();
         end else if (due.size() > 0 && due[0] == ncyc) begin
            void'(due.pop_front());
            if (resp_cnt == err_at) err = 1'b1;
            else ack = 1'b1;
            resp_cnt++;
            last_resp_cyc = cyc;
         end
         if (rst !== 1'b1 && prev_held && (stb !== 1'b1 || dat !== prev_dat || adr !== prev_adr))
            hold_viol++;
         stall = (stall_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
         if (stb === 1'b1) stb_cycles++;
         prev_held = (stb === 1'b1) && stall;
         prev_dat  = dat;
         prev_adr  = adr;
         if (stb === 1'b1 && !stall && rst !== 1'b1) begin
            cap_dat.push_back(dat);
            cap_adr.push_back(adr);
            acc_cnt++;
            due.push_back(ncyc + ack_delay);
         end
      end
   end

   function automatic logic [63:0] exp_word(input logic [15:0] base, input int i);
      return {16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i), base + 16'(i)};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      vld = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_samples(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vld = 1'b1;
         ch0 = base + 16'(i);
         ch1 = 16'h1000 + 16'(i);
         ch2 = 16'h2000 + 16'(i);
         ch3 = 16'h3000 + 16'(i);
      end
      @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (acc_cnt >= target && cyc === 1'b0) break;
      end
      total++;
      if (k >= budget) begin
         bad++;
         $display("FAIL %s_timeout: accepted %0d, needed %0d within %0d cycles", name, acc_cnt, target, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; vld = 1'b0;
      ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;
      repeat (3) @(negedge clk);
      total++; if (cyc !== 1'b0)       begin bad++; $display("FAIL reset_cyc: got %b want 0", cyc); end
      total++; if (stb !== 1'b0)       begin bad++; $display("FAIL reset_stb: got %b want 0", stb); end
      total++; if (we !== 1'b0)        begin bad++; $display("FAIL reset_we: got %b want 0", we); end
      total++; if (sel !== 8'h00)      begin bad++; $display("FAIL reset_sel: got %h want 00", sel); end
      total++; if (adr !== 2'd0)       begin bad++; $display("FAIL reset_adr: got %0d want 0", adr); end
      total++; if (dat !== 64'h0)      begin bad++; $display("FAIL reset_dat: got %h want 0", dat); end
      total++; if (level !== 9'd0)     begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
      total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      total++; if (err_flag !== 1'b0)  begin bad++; $display("FAIL reset_err: got %b want 0", err_flag); end
      rst = 1'b0;
   endtask

   task automatic test_single_packet();
      int a0, r0, s0;
      apply_reset();
      en = 1'b1; stall_mode = 0; ack_delay = 1; err_at = -1;
      a0 = acc_cnt; r0 = resp_cnt; s0 = stb_cycles;
      push_samples(32, 16'h0000);
      total++; if (level !== 9'd32) begin bad++; $display("FAIL single_level: got %0d want 32", level); end
      total++; if (cyc !== 1'b0)    begin bad++; $display("FAIL single_early_cyc: got %b want 0", cyc); end
      @(negedge clk);
      total++; if (cyc !== 1'b1 || stb !== 1'b1 || we !== 1'b1)
         begin bad++; $display("FAIL single_start: cyc/stb/we got %b%b%b want 111", cyc, stb, we); end
      total++; if (sel !== 8'hFF)   begin bad++; $display("FAIL single_sel: got %h want ff", sel); end
      total++; if (adr !== 2'd0 || dat !== exp_word(16'h0000, 0))
         begin bad++; $display("FAIL single_head: adr %0d dat %h want 0 %h", adr, dat, exp_word(16'h0000, 0)); end
      wait_done(a0 + 33, 200, "single");
      total++; if (acc_cnt - a0 != 33)    begin bad++; $display("FAIL single_accepts: got %0d want 33", acc_cnt - a0); end
      total++; if (stb_cycles - s0 != 33) begin bad++; $display("FAIL single_stb_cycles: got %0d want 33", stb_cycles - s0); end
      total++; if (resp_cnt - r0 != 33)   begin bad++; $display("FAIL single_responses: got %0d want 33", resp_cnt - r0); end
      total++; if (last_resp_cyc !== 1'b1) begin bad++; $display("FAIL single_cyc_at_last_ack: got %b want 1", last_resp_cyc); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (cap_adr[a0+i] !== 2'd0 || cap_dat[a0+i] !== exp_word(16'h0000, i)) begin
            bad++; $display("FAIL single_word%0d: adr %0d dat %h want 0 %h", i, cap_adr[a0+i], cap_dat[a0+i], exp_word(16'h0000, i));
         end
      end
      total++;
      if (cap_adr[a0+32] !== 2'd1 || cap_dat[a0+32] !== 64'h0000_0000_0000_0020) begin
         bad++; $display("FAIL single_status: adr %0d dat %h want 1 0000000000000020", cap_adr[a0+32], cap_dat[a0+32]);
      end
      total++; if (level !== 9'd0) begin bad++; $display("FAIL single_level_end: got %0d want 0", level); end
   endtask

   task automatic test_stall();
      int a0, h0;
      apply_reset();
      en = 1'b1; stall_mode = 1; ack_delay = 1; err_at = -1;
      a0 = acc_cnt; h0 = hold_viol;
      push_samples(32, 16'h0040);
      wait_done(a0 + 33, 600, "stall");
      stall_mode = 0;
      total++; if (acc_cnt - a0 != 33)   begin bad++; $display("FAIL stall_accepts: got %0d want 33", acc_cnt - a0); end
      total++; if (hold_viol - h0 != 0)  begin bad++; $display("FAIL stall_hold: %0d unstable stalled cycles, want 0", hold_viol - h0); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (cap_adr[a0+i] !== 2'd0 || cap_dat[a0+i] !== exp_word(16'h0040, i)) begin
            bad++; $display("FAIL stall_word%0d: adr %0d dat %h want 0 %h", i, cap_adr[a0+i], cap_dat[a0+i], exp_word(16'h0040, i));
         end
      end
      total++;
      if (cap_adr[a0+32] !== 2'd1 || cap_dat[a0+32] !== 64'h0000_0000_0000_0020) begin
         bad++; $display("FAIL stall_status: adr %0d dat %h want 1 0000000000000020", cap_adr[a0+32], cap_dat[a0+32]);
      end
   endtask

   task automatic test_overflow();
      int a0, o0, c0;
      apply_reset();
      en = 1'b0; o0 = ovf_seen;
      push_samples(260, 16'h0000);
      @(negedge clk);
      total++; if (ovf_seen - o0 != 4) begin bad++; $display("FAIL ovf_pulses: got %0d want 4", ovf_seen - o0); end
      total++; if (level !== 9'd256)   begin bad++; $display("FAIL ovf_level: got %0d want 256", level); end
      a0 = acc_cnt; c0 = cyc_rises;
      en = 1'b1;
      wait_done(a0 + 264, 2000, "ovf_drain");
      total++; if (acc_cnt - a0 != 264)  begin bad++; $display("FAIL ovf_accepts: got %0d want 264", acc_cnt - a0); end
      total++; if (cyc_rises - c0 != 8)  begin bad++; $display("FAIL b2b_cyc_gaps: got %0d cyc starts want 8", cyc_rises - c0); end
      total++; if (cap_dat[a0+32] !== 64'h0000_0004_0000_0020)
         begin bad++; $display("FAIL ovf_status0: got %h want 0000000400000020", cap_dat[a0+32]); end
      total++; if (cap_dat[a0+65] !== 64'h0001_0000_0000_0020)
         begin bad++; $display("FAIL ovf_status1: got %h want 0001000000000020", cap_dat[a0+65]); end
      total++; if (cap_dat[a0+263] !== 64'h0007_0000_0000_0020)
         begin bad++; $display("FAIL ovf_status7: got %h want 0007000000000020", cap_dat[a0+263]); end
      total++; if (cap_dat[a0+33*7+31] !== exp_word(16'h0000, 255))
         begin bad++; $display("FAIL ovf_last_word: got %h want %h", cap_dat[a0+33*7+31], exp_word(16'h0000, 255)); end
      total++; if (level !== 9'd0) begin bad++; $display("FAIL ovf_level_end: got %0d want 0", level); end
   endtask

   task automatic test_full_boundary();
      int a0, o0, a1;
      apply_reset();
      en = 1'b0; o0 = ovf_seen;
      push_samples(256, 16'h0000);
      a0 = acc_cnt;
      en = 1'b1;
      push_samples(20, 16'h0500);
      en = 1'b0;
      wait_done(a0 + 33, 300, "full");
      @(negedge clk);
      total++; if (ovf_seen - o0 != 0)  begin bad++; $display("FAIL full_ovf: got %0d pulses want 0", ovf_seen - o0); end
      total++; if (acc_cnt - a0 != 33)  begin bad++; $display("FAIL full_accepts: got %0d want 33", acc_cnt - a0); end
      total++; if (cap_adr[acc_cnt-1] !== 2'd1) begin bad++; $display("FAIL full_last_adr: got %0d want 1", cap_adr[acc_cnt-1]); end
      total++; if (level !== 9'd244)    begin bad++; $display("FAIL full_level: got %0d want 244", level); end
      a1 = acc_cnt;
      repeat (40) @(negedge clk);
      total++; if (cyc !== 1'b0 || acc_cnt != a1)
         begin bad++; $display("FAIL disable_no_restart: cyc %b new accepts %0d want 0 0", cyc, acc_cnt - a1); end
   endtask

   task automatic test_seq_wrap();
      int a0;
      apply_reset();
      en = 1'b0;
      @(negedge clk);
      force dut.pkt_seq = 16'hFFFF;
      @(negedge clk);
      release dut.pkt_seq;
      en = 1'b1; a0 = acc_cnt;
      push_samples(64, 16'h0100);
      wait_done(a0 + 66, 600, "wrap");
      total++; if (cap_dat[a0+32] !== 64'hFFFF_0000_0000_0020)
         begin bad++; $display("FAIL wrap_status0: got %h want ffff000000000020", cap_dat[a0+32]); end
      total++; if (cap_dat[a0+65] !== 64'h0000_0000_0000_0020)
         begin bad++; $display("FAIL wrap_status1: got %h want 0000000000000020", cap_dat[a0+65]); end
   endtask

   task automatic test_delayed_err();
      int a0, r0;
      apply_reset();
      en = 1'b1; ack_delay = 5; a0 = acc_cnt; r0 = resp_cnt;
      err_at = resp_cnt + 10;
      push_samples(32, 16'h0200);
      wait_done(a0 + 33, 400, "delayed");
      total++; if (resp_cnt - r0 != 33)     begin bad++; $display("FAIL delayed_responses: got %0d want 33", resp_cnt - r0); end
      total++; if (last_resp_cyc !== 1'b1)  begin bad++; $display("FAIL delayed_cyc_held: got %b want 1", last_resp_cyc); end
      total++; if (err_flag !== 1'b1)       begin bad++; $display("FAIL delayed_err_set: got %b want 1", err_flag); end
      repeat (10) @(negedge clk);
      total++; if (err_flag !== 1'b1)       begin bad++; $display("FAIL delayed_err_sticky: got %b want 1", err_flag); end
      ack_delay = 1; err_at = -1;
   endtask

   task automatic test_reset_mid();
      int a0, a1, k;
      apply_reset();
      total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL rst_clears_err: got %b want 0", err_flag); end
      en = 1'b1; a0 = acc_cnt;
      push_samples(32, 16'h0300);
      wait_done(a0 + 33, 200, "pre_abort");
      a0 = acc_cnt;
      push_samples(32, 16'h0380);
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (acc_cnt - a0 >= 10) break;
      end
      rst = 1'b1;
      @(negedge clk);
      total++; if (cyc !== 1'b0 || stb !== 1'b0) begin bad++; $display("FAIL midrst_cyc: cyc/stb got %b%b want 00", cyc, stb); end
      total++; if (level !== 9'd0)  begin bad++; $display("FAIL midrst_level: got %0d want 0", level); end
      @(negedge clk);
      rst = 1'b0;
      a1 = acc_cnt;
      push_samples(32, 16'h0400);
      wait_done(a1 + 33, 200, "post_abort");
      total++; if (cap_dat[a1] !== exp_word(16'h0400, 0))
         begin bad++; $display("FAIL midrst_first_word: got %h want %h", cap_dat[a1], exp_word(16'h0400, 0)); end
      total++; if (cap_dat[a1+32] !== 64'h0000_0000_0000_0020)
         begin bad++; $display("FAIL midrst_status: got %h want 0000000000000020", cap_dat[a1+32]); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_packet();
      test_stall();
      test_overflow();
      test_full_boundary();
      test_seq_wrap();
      test_delayed_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
